nw_stream_aligner: RTL and testbench
====================================

NW_STREAM_ALIGNER -- requirements
Module: nw_stream_aligner

Interface
REQ-001 Parameter LEN1_MAX, default 8, max characters of s1.
REQ-002 Parameter LEN2_MAX, default 8, max characters of s2.
REQ-003 Parameter CWIDTH, default 2, bits per character.
REQ-004 Parameter SWIDTH, default 16, signed score width.
REQ-005 Parameters MATCH=1, MISMATCH=-1, INDEL=-1, signed weights.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  request; sampled only in IDLE.
REQ-009 s1  in  LEN1_MAX*CWIDTH  string 1; char i at [i*CWIDTH +: CWIDTH].
REQ-010 s2  in  LEN2_MAX*CWIDTH  string 2, same packing.
REQ-011 len1 / len2  in  clog2(MAXn+1)  runtime lengths.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 score  out  SWIDTH  final H(len1,len2), held until next start.
REQ-014 score_valid  out  1  one-cycle pulse when score is final.
REQ-015 op  out  2  traceback op: 0 MATCH, 1 MISMATCH, 2 UP (s1 char vs gap), 3 LEFT (gap vs s2 char).
REQ-016 op_valid / op_ready / op_last  out/in/out  1 each  valid-ready op stream; op_last marks the final op.
REQ-017 done  out  1  one-cycle pulse at end of job.
REQ-018 err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-019 The FSM SHALL have states IDLE, INIT, FILL, TRACE, FIN.
REQ-020 IDLE + start: if len1>LEN1_MAX or len2>LEN2_MAX, pulse err next cycle and stay IDLE; else latch s1, s2, len1, len2 and go to INIT.
REQ-021 start outside IDLE SHALL be ignored with no err.
REQ-022 INIT (1 cycle): row buffer R[j] = j*INDEL for j=0..len2; next FILL if len1>0 and len2>0, else TRACE.
REQ-023 FILL SHALL compute one cell per cycle, row-major i=1..len1, j=1..len2: H = max(Hdiag + (s1[i-1]==s2[j-1] ? MATCH : MISMATCH), Hup+INDEL, Hleft+INDEL); store a 2-bit direction per cell.
REQ-024 Ties SHALL resolve diag > up > left.
REQ-025 Row boundary: Hleft at j=1 SHALL be i*INDEL.
REQ-026 Arithmetic SHALL be two's-complement SWIDTH with no saturation; SWIDTH sufficiency is the integrator's responsibility.
REQ-027 With start sampled at edge T, score_valid SHALL pulse in cycle T+2+len1*len2 as TRACE is entered; if len1 or len2 is 0, in cycle T+2 with score=(len1+len2)*INDEL.
REQ-028 TRACE SHALL walk from (len1,len2) toward (0,0) and emit one op per accepted transfer, end-to-start order.
REQ-029 Direction diag SHALL emit MATCH or MISMATCH per character compare; i==0 forces LEFT; j==0 forces UP.
REQ-030 op and op_last SHALL be stable while op_valid=1 and op_ready=0; a transfer occurs only when both are high.
REQ-031 op_last SHALL be asserted with the op that reaches (0,0); the next cycle is FIN.
REQ-032 len1=len2=0: no ops emitted; TRACE goes straight to FIN.
REQ-033 FIN SHALL pulse done for one cycle, then return to IDLE.

Reset
REQ-034 Reset SHALL force IDLE and drive busy, score_valid, op_valid, op_last, done and err to 0 and score to 0, including mid-FILL or mid-TRACE; pending ops are dropped.
REQ-035 Direction memory and row buffer contents need no reset.

Structure
REQ-036 A shared package nw_pkg SHALL hold the op encoding, the state enum, and the direction encoding (DIR_DIAG, DIR_UP, DIR_LEFT).
REQ-037 The cell recurrence SHALL live in one sub-module nw_score_pe: combinational 3-way max with tie rule, returning score and direction.
REQ-038 Direction storage SHALL be a LEN1_MAX*LEN2_MAX x 2-bit array inside the top module.

Verification (MATCH=1, MISMATCH=-1, INDEL=-1; A=0, C=1, G=2, T=3)
REQ-039 s1=ACGT, s2=ACGT, op_ready=1 -> score=4; score_valid at T+18; 4 MATCH ops, op_last on 4th; done next cycle.
REQ-040 s1=AC, s2=A -> score=0; ops UP then MATCH (op_last); s1=A, s2=C -> score=-1, single MISMATCH.
REQ-041 len1=0, len2=3 -> score=-3 at T+2; LEFT,LEFT,LEFT with op_last on 3rd; len1=len2=0 -> score=0, no ops, done.
REQ-042 Hold op_ready=0 for 5 cycles during TRACE -> op, op_valid and op_last unchanged; no op lost or duplicated after release.
REQ-043 Reset mid-FILL -> all outputs 0 next cycle, IDLE; a new start then completes correctly; start while busy is ignored; len1=9 with LEN1_MAX=8 -> err pulse, busy stays 0.

Source files
------------

// File: rtl/nw_pkg.sv
// Shared encodings for the Needleman-Wunsch stream aligner: FSM states,
// traceback op codes and the per-cell direction code.
package nw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FILL,
    TRACE,
    FIN
  } state_t;

  typedef enum logic [1:0] {
    OP_MATCH    = 2'd0,
    OP_MISMATCH = 2'd1,
    OP_UP       = 2'd2,
    OP_LEFT     = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    DIR_DIAG = 2'd0,
    DIR_UP   = 2'd1,
    DIR_LEFT = 2'd2
  } dir_t;

endpackage

// File: rtl/nw_stream_aligner_if.sv
// Job request / result / traceback-op bundle of the aligner.
// The master drives requests and op_ready; the slave is the aligner.
interface nw_stream_aligner_if #(
  parameter int LEN1_MAX = 8,
  parameter int LEN2_MAX = 8,
  parameter int CWIDTH   = 2,
  parameter int SWIDTH   = 16
);
  localparam int L1W = $clog2(LEN1_MAX + 1);
  localparam int L2W = $clog2(LEN2_MAX + 1);

  logic                       start;
  logic [LEN1_MAX*CWIDTH-1:0] s1;
  logic [LEN2_MAX*CWIDTH-1:0] s2;
  logic [L1W-1:0]             len1;
  logic [L2W-1:0]             len2;
  logic                       busy;
  logic [SWIDTH-1:0]          score;
  logic                       score_valid;
  logic [1:0]                 op;
  logic                       op_valid;
  logic                       op_ready;
  logic                       op_last;
  logic                       done;
  logic                       err;

  modport master (
    output start, s1, s2, len1, len2, op_ready,
    input  busy, score, score_valid, op, op_valid, op_last, done, err
  );

  modport slave (
    input  start, s1, s2, len1, len2, op_ready,
    output busy, score, score_valid, op, op_valid, op_last, done, err
  );
endinterface

// File: rtl/nw_score_pe.sv
// One cell of the alignment recurrence: 3-way max with ties resolved
// diagonal first, then up, then left.
module nw_score_pe import nw_pkg::*; #(
  parameter int SWIDTH   = 16,
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int INDEL    = -1
) (
  input  logic signed [SWIDTH-1:0] h_diag,
  input  logic signed [SWIDTH-1:0] h_up,
  input  logic signed [SWIDTH-1:0] h_left,
  input  logic                     is_match,
  output logic signed [SWIDTH-1:0] h,
  output dir_t                     dir
);
  localparam logic signed [SWIDTH-1:0] W_MATCH    = SWIDTH'(MATCH);
  localparam logic signed [SWIDTH-1:0] W_MISMATCH = SWIDTH'(MISMATCH);
  localparam logic signed [SWIDTH-1:0] W_INDEL    = SWIDTH'(INDEL);

  logic signed [SWIDTH-1:0] cand_diag, cand_up, cand_left;

  always_comb begin
    cand_diag = h_diag + (is_match ? W_MATCH : W_MISMATCH);
    cand_up   = h_up + W_INDEL;
    cand_left = h_left + W_INDEL;
    if (cand_diag >= cand_up && cand_diag >= cand_left) begin
      h   = cand_diag;
      dir = DIR_DIAG;
    end else if (cand_up >= cand_left) begin
      h   = cand_up;
      dir = DIR_UP;
    end else begin
      h   = cand_left;
      dir = DIR_LEFT;
    end
  end
endmodule

// File: rtl/nw_stream_aligner.sv
// Global alignment engine: fills the score matrix one cell per cycle using a
// single row buffer, then streams the traceback ops end-to-start.
module nw_stream_aligner import nw_pkg::*; #(
  parameter int LEN1_MAX = 8,
  parameter int LEN2_MAX = 8,
  parameter int CWIDTH   = 2,
  parameter int SWIDTH   = 16,
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int INDEL    = -1
) (
  input logic               clk,
  input logic               reset,
  nw_stream_aligner_if.slave bus
);
  localparam int L1W   = $clog2(LEN1_MAX + 1);
  localparam int L2W   = $clog2(LEN2_MAX + 1);
  localparam int CELLS = LEN1_MAX * LEN2_MAX;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int B1W   = (LEN1_MAX * CWIDTH > 1) ? $clog2(LEN1_MAX * CWIDTH) : 1;
  localparam int B2W   = (LEN2_MAX * CWIDTH > 1) ? $clog2(LEN2_MAX * CWIDTH) : 1;
  localparam logic signed [SWIDTH-1:0] W_INDEL = SWIDTH'(INDEL);

  state_t                     state;
  logic [LEN1_MAX*CWIDTH-1:0] s1_q;
  logic [LEN2_MAX*CWIDTH-1:0] s2_q;
  logic [L1W-1:0]             len1_q, i;
  logic [L2W-1:0]             len2_q, j;
  logic signed [SWIDTH-1:0]   diag_q, left_q, rowb_q;
  logic signed [SWIDTH-1:0]   rowbuf [0:LEN2_MAX];
  dir_t                       dir_mem [CELLS];

  logic                       busy_q, score_valid_q, op_valid_q, op_last_q, done_q, err_q;
  logic signed [SWIDTH-1:0]   score_q;
  op_t                        op_q;

  int                         im1, jm1;
  logic [IW-1:0]              cell_idx;
  logic [B1W-1:0]             c1_base;
  logic [B2W-1:0]             c2_base;
  logic                       is_match;
  logic signed [SWIDTH-1:0]   pe_h;
  dir_t                       pe_dir;
  op_t                        tr_op;
  logic [L1W-1:0]             tr_i;
  logic [L2W-1:0]             tr_j;
  logic                       tr_last;

  // (i, j) is the fill cursor in FILL and the traceback position in TRACE.
  always_comb begin
    im1      = (i == '0) ? 0 : int'(i) - 1;
    jm1      = (j == '0) ? 0 : int'(j) - 1;
    cell_idx = IW'(im1 * LEN2_MAX + jm1);
    c1_base  = B1W'(im1 * CWIDTH);
    c2_base  = B2W'(jm1 * CWIDTH);
    is_match = (s1_q[c1_base +: CWIDTH] == s2_q[c2_base +: CWIDTH]);
  end

  nw_score_pe #(
    .SWIDTH  (SWIDTH),
    .MATCH   (MATCH),
    .MISMATCH(MISMATCH),
    .INDEL   (INDEL)
  ) u_pe (
    .h_diag  (diag_q),
    .h_up    (rowbuf[j]),
    .h_left  (left_q),
    .is_match(is_match),
    .h       (pe_h),
    .dir     (pe_dir)
  );

  always_comb begin
    tr_op = OP_LEFT;
    tr_i  = i;
    tr_j  = j;
    if (i == '0) begin
      tr_op = OP_LEFT;
      tr_j  = j - L2W'(1);
    end else if (j == '0) begin
      tr_op = OP_UP;
      tr_i  = i - L1W'(1);
    end else begin
      unique case (dir_mem[cell_idx])
        DIR_DIAG: begin
          tr_op = is_match ? OP_MATCH : OP_MISMATCH;
          tr_i  = i - L1W'(1);
          tr_j  = j - L2W'(1);
        end
        DIR_UP: begin
          tr_op = OP_UP;
          tr_i  = i - L1W'(1);
        end
        default: begin
          tr_op = OP_LEFT;
          tr_j  = j - L2W'(1);
        end
      endcase
    end
    tr_last = (tr_i == '0) && (tr_j == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy_q        <= 1'b0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      op_q          <= OP_MATCH;
      op_valid_q    <= 1'b0;
      op_last_q     <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      i             <= '0;
      j             <= '0;
    end else begin
      score_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.len1 > L1W'(LEN1_MAX) || bus.len2 > L2W'(LEN2_MAX)) begin
              err_q <= 1'b1;
            end else begin
              s1_q   <= bus.s1;
              s2_q   <= bus.s2;
              len1_q <= bus.len1;
              len2_q <= bus.len2;
              busy_q <= 1'b1;
              state  <= INIT;
            end
          end
        end
        INIT: begin
          for (int unsigned k = 0; k < LEN2_MAX + 1; k++) begin
            rowbuf[L2W'(k)] <= SWIDTH'(int'(k) * INDEL);
          end
          diag_q <= '0;
          left_q <= W_INDEL;
          rowb_q <= W_INDEL;
          if (len1_q != '0 && len2_q != '0) begin
            i     <= L1W'(1);
            j     <= L2W'(1);
            state <= FILL;
          end else begin
            i             <= len1_q;
            j             <= len2_q;
            score_q       <= SWIDTH'((int'(len1_q) + int'(len2_q)) * INDEL);
            score_valid_q <= 1'b1;
            state         <= TRACE;
          end
        end
        FILL: begin
          dir_mem[cell_idx] <= pe_dir;
          rowbuf[j]         <= pe_h;
          if (j == len2_q) begin
            if (i == len1_q) begin
              // cursor stays on (len1, len2), which is where traceback begins
              score_q       <= pe_h;
              score_valid_q <= 1'b1;
              state         <= TRACE;
            end else begin
              i      <= i + L1W'(1);
              j      <= L2W'(1);
              diag_q <= rowb_q;
              left_q <= rowb_q + W_INDEL;
              rowb_q <= rowb_q + W_INDEL;
            end
          end else begin
            j      <= j + L2W'(1);
            diag_q <= rowbuf[j];
            left_q <= pe_h;
          end
        end
        TRACE: begin
          if (!op_valid_q || bus.op_ready) begin
            if (op_valid_q && op_last_q) begin
              op_valid_q <= 1'b0;
              op_last_q  <= 1'b0;
              state      <= FIN;
            end else if (i == '0 && j == '0) begin
              op_valid_q <= 1'b0;
              state      <= FIN;
            end else begin
              op_q       <= tr_op;
              op_last_q  <= tr_last;
              op_valid_q <= 1'b1;
              i          <= tr_i;
              j          <= tr_j;
            end
          end
        end
        FIN: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.score       = score_q;
  assign bus.score_valid = score_valid_q;
  assign bus.op          = op_q;
  assign bus.op_valid    = op_valid_q;
  assign bus.op_last     = op_last_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_nw_stream_aligner.sv
// Bench for nw_stream_aligner: full-matrix reference alignment per job,
// one negedge compare process for scores, op stream, done, err and busy.
module tb_nw_stream_aligner;
  localparam int L1 = 8;
  localparam int L2 = 8;
  localparam int CW = 2;
  localparam int SW = 16;
  localparam int L1W = $clog2(L1 + 1);
  localparam int L2W = $clog2(L2 + 1);
  localparam int W_MATCH = 1;
  localparam int W_MIS   = -1;
  localparam int W_INDEL = -1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nw_stream_aligner_if #(.LEN1_MAX(L1), .LEN2_MAX(L2), .CWIDTH(CW), .SWIDTH(SW)) bus ();

  nw_stream_aligner #(
    .LEN1_MAX(L1), .LEN2_MAX(L2), .CWIDTH(CW), .SWIDTH(SW),
    .MATCH(W_MATCH), .MISMATCH(W_MIS), .INDEL(W_INDEL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int m1[L1];
  int m2[L2];
  int exp_q[$];
  int exp_score;
  bit job_active = 1'b0;
  bit had_ops = 1'b0;
  int sv_cyc = -1;
  int err_cyc = -1;
  int last_xfer_cyc = -1;
  int rmode = 0;
  int stall_left = 0;

  task automatic chk(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference: whole DP matrix, then walk back from (l1, l2).
  task automatic build_model(input int l1, input int l2);
    int h[L1+1][L2+1];
    int d[L1+1][L2+1];
    int a, b, dg, up, lf;
    for (int x = 0; x <= l1; x++) h[x][0] = x * W_INDEL;
    for (int y = 0; y <= l2; y++) h[0][y] = y * W_INDEL;
    for (int x = 1; x <= l1; x++)
      for (int y = 1; y <= l2; y++) begin
        dg = h[x-1][y-1] + ((m1[x-1] == m2[y-1]) ? W_MATCH : W_MIS);
        up = h[x-1][y] + W_INDEL;
        lf = h[x][y-1] + W_INDEL;
        if (dg >= up && dg >= lf) begin h[x][y] = dg; d[x][y] = 0; end
        else if (up >= lf)        begin h[x][y] = up; d[x][y] = 1; end
        else                      begin h[x][y] = lf; d[x][y] = 2; end
      end
    exp_score = h[l1][l2];
    exp_q.delete();
    a = l1;
    b = l2;
    while (a > 0 || b > 0) begin
      if (a == 0)               begin exp_q.push_back(3); b--; end
      else if (b == 0)          begin exp_q.push_back(2); a--; end
      else if (d[a][b] == 0)    begin exp_q.push_back((m1[a-1] == m2[b-1]) ? 0 : 1); a--; b--; end
      else if (d[a][b] == 1)    begin exp_q.push_back(2); a--; end
      else                      begin exp_q.push_back(3); b--; end
    end
  endtask

  task automatic pin(input string name, input int score_lit, input int n_lit, input int code_lit);
    int code = 0;
    foreach (exp_q[k]) code = code * 4 + exp_q[k];
    chk({name, "_score"}, exp_score, score_lit);
    chk({name, "_nops"}, exp_q.size(), n_lit);
    chk({name, "_ops"}, code, code_lit);
  endtask

  task automatic rand_strings();
    for (int k = 0; k < L1; k++) m1[k] = int'($urandom_range(0, 3));
    for (int k = 0; k < L2; k++) m2[k] = int'($urandom_range(0, 3));
  endtask

  task automatic drive_strings();
    logic [L1*CW-1:0] v1;
    logic [L2*CW-1:0] v2;
    for (int k = 0; k < L1; k++) v1[k*CW +: CW] = CW'(m1[k]);
    for (int k = 0; k < L2; k++) v2[k*CW +: CW] = CW'(m2[k]);
    bus.s1 = v1;
    bus.s2 = v2;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_score_valid"}, int'(bus.score_valid), 0);
    chk({tag, "_op_valid"}, int'(bus.op_valid), 0);
    chk({tag, "_op_last"}, int'(bus.op_last), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_score"}, int'(bus.score), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic run_job(input int l1, input int l2, input int mode, input bit poke);
    int n;
    build_model(l1, l2);
    step();
    drive_strings();
    bus.len1   = L1W'(l1);
    bus.len2   = L2W'(l2);
    bus.start  = 1'b1;
    rmode      = mode;
    stall_left = 5;
    had_ops    = (exp_q.size() > 0);
    sv_cyc     = cyc + 2 + l1 * l2;
    job_active = 1'b1;
    step();
    bus.start = 1'b0;
    if (poke) begin
      step();
      bus.start = 1'b1;
      bus.len1  = L1W'(9);
      bus.s1    = ~bus.s1;
      step();
      bus.start = 1'b0;
    end
    n = 0;
    while (job_active && n < 2000) begin
      step();
      n++;
    end
    if (job_active) begin
      chk("job_timeout", 1, 0);
      job_active = 1'b0;
      exp_q.delete();
      pulse_reset();
    end
  endtask

  // Single compare process: decides op_ready, then checks every output.
  initial begin
    bit rdy;
    bit prev_hold;
    int prev_op;
    bit prev_last;
    bit lastexp;
    int e;
    prev_hold = 1'b0;
    prev_op   = 0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        case (rmode)
          1: rdy = 1'($urandom_range(0, 1));
          2: if (bus.op_valid && stall_left > 0) begin rdy = 1'b0; stall_left--; end else rdy = 1'b1;
          default: rdy = 1'b1;
        endcase
        bus.op_ready = rdy;
        if (prev_hold) begin
          chk("hold_op_valid", int'(bus.op_valid), 1);
          chk("hold_op", int'(bus.op), prev_op);
          chk("hold_op_last", int'(bus.op_last), int'(prev_last));
        end
        prev_hold = bus.op_valid && !rdy;
        prev_op   = int'(bus.op);
        prev_last = bus.op_last;
        if (bus.op_valid && rdy) begin
          if (!job_active || exp_q.size() == 0) begin
            chk("unexpected_op", int'(bus.op), -1);
          end else begin
            e = exp_q.pop_front();
            lastexp = (exp_q.size() == 0);
            chk("op", int'(bus.op), e);
            chk("op_last", int'(bus.op_last), int'(lastexp));
            if (lastexp) last_xfer_cyc = cyc;
          end
        end
        if (bus.score_valid || (job_active && cyc == sv_cyc)) begin
          chk("score_valid", int'(bus.score_valid), int'(job_active && cyc == sv_cyc));
          if (bus.score_valid) chk("score", int'($signed(bus.score)), exp_score);
        end
        if (bus.done) begin
          chk("done_cycle", cyc, job_active ? (had_ops ? last_xfer_cyc + 2 : sv_cyc + 2) : -1);
          chk("ops_left_at_done", exp_q.size(), 0);
          job_active = 1'b0;
          exp_q.delete();
        end
        if (bus.err || cyc == err_cyc) chk("err", int'(bus.err), int'(cyc == err_cyc));
        chk("busy", int'(bus.busy), int'(job_active));
      end
    end
  end

  initial begin
    bus.start    = 1'b0;
    bus.s1       = '0;
    bus.s2       = '0;
    bus.len1     = '0;
    bus.len2     = '0;
    bus.op_ready = 1'b1;
    reset        = 1'b1;
    repeat (3) step();
    chk_idle_outputs("reset");
    reset = 1'b0;

    m1 = '{0, 1, 2, 3, 0, 0, 0, 0};
    m2 = '{0, 1, 2, 3, 0, 0, 0, 0};
    build_model(4, 4);
    pin("model_acgt", 4, 4, 0);
    run_job(4, 4, 0, 1'b0);

    m1 = '{0, 1, 3, 3, 3, 3, 3, 3};
    m2 = '{0, 2, 2, 2, 2, 2, 2, 2};
    build_model(2, 1);
    pin("model_ac_a", 0, 2, 8);
    run_job(2, 1, 0, 1'b0);

    m1 = '{0, 0, 0, 0, 0, 0, 0, 0};
    m2 = '{1, 1, 1, 1, 1, 1, 1, 1};
    build_model(1, 1);
    pin("model_a_c", -1, 1, 1);
    run_job(1, 1, 0, 1'b0);

    rand_strings();
    build_model(0, 3);
    pin("model_0_3", -3, 3, 63);
    run_job(0, 3, 0, 1'b0);
    build_model(0, 0);
    pin("model_0_0", 0, 0, 0);
    run_job(0, 0, 0, 1'b0);
    run_job(5, 0, 1, 1'b0);

    rand_strings();
    run_job(4, 5, 2, 1'b0);
    rand_strings();
    run_job(3, 3, 0, 1'b1);

    step();
    bus.len1  = L1W'(9);
    bus.len2  = L2W'(2);
    bus.start = 1'b1;
    err_cyc   = cyc + 1;
    step();
    bus.start = 1'b0;
    chk("err_busy", int'(bus.busy), 0);
    step();
    chk("err_single_pulse", int'(bus.err), 0);

    rand_strings();
    step();
    drive_strings();
    bus.len1   = L1W'(8);
    bus.len2   = L2W'(8);
    bus.start  = 1'b1;
    sv_cyc     = cyc + 66;
    job_active = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    reset      = 1'b1;
    job_active = 1'b0;
    exp_q.delete();
    step();
    chk_idle_outputs("midfill_reset");
    reset = 1'b0;
    rand_strings();
    run_job(8, 8, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rand_strings();
      run_job(int'($urandom_range(0, L1)), int'($urandom_range(0, L2)),
              int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
